// File: rtl/alu_pkg.sv
// Shared ALU opcodes and the sorter state encoding.
// Imported by the sorter and by anything that drives the lab ALU.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } sort_state_t;

endpackage

// File: rtl/alu_sort_driver.sv
// Bubble-sorts N words in place, one external-ALU SUB compare per cycle (N*(N-1)/2 cycles).
// Define ALU_SORT_SIGNED_EN for a two's-complement compare; default build compares unsigned.
module alu_sort_driver
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_m,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cf,
    input  logic             alu_of
);

    localparam int            IW        = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

    sort_state_t      state_q, state_d;
    logic [IW-1:0]    count_q, count_d;
    logic [IW-1:0]    pass_q, pass_d;
    logic [IW-1:0]    j_q, j_d;
    logic [WIDTH-1:0] x_q [N];
    logic [WIDTH-1:0] x_d [N];
    logic [IW-1:0]    j_nxt;
    logic             lt;
    logic             unused_alu;

    assign j_nxt = j_q + IW'(1);
    assign alu_m = ALU_SUB;

    // alu_a - alu_b = x[j+1] - x[j]; a borrow / negative result means x[j+1] < x[j].
`ifdef ALU_SORT_SIGNED_EN
    assign lt = alu_of ^ alu_y[WIDTH-1];
`else
    assign lt = alu_cf;
`endif
    assign unused_alu = ^{alu_y, alu_of, alu_cf};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pass_d    = pass_q;
        j_d       = j_q;
        x_d       = x_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        alu_a     = '0;
        alu_b     = '0;

        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    x_d[count_q] = in_data;
                    if (count_q == LAST_IDX) begin
                        state_d = SORT;
                        count_d = '0;
                        pass_d  = '0;
                        j_d     = '0;
                    end else begin
                        count_d = count_q + IW'(1);
                    end
                end
            end

            SORT: begin
                busy  = 1'b1;
                alu_a = x_q[j_nxt];
                alu_b = x_q[j_q];
                // Strict less-than only, so equal words keep their order.
                if (lt) begin
                    x_d[j_q]   = x_q[j_nxt];
                    x_d[j_nxt] = x_q[j_q];
                end
                if (j_q == LAST_PASS - pass_q) begin
                    j_d = '0;
                    if (pass_q == LAST_PASS) begin
                        state_d = OUT;
                    end else begin
                        pass_d = pass_q + IW'(1);
                    end
                end else begin
                    j_d = j_nxt;
                end
            end

            OUT: begin
                out_valid = 1'b1;
                out_data  = x_q[count_q];
                if (out_ready) begin
                    if (count_q == LAST_IDX) begin
                        state_d = LOAD;
                        count_d = '0;
                    end else begin
                        count_d = count_q + IW'(1);
                    end
                end
            end

            default: begin
                state_d = LOAD;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            count_q <= '0;
            pass_q  <= '0;
            j_q     <= '0;
            for (int i = 0; i < N; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pass_q  <= pass_d;
            j_q     <= j_d;
            x_q     <= x_d;
        end
    end

endmodule

// File: tb/tb_alu_sort_driver.sv
// Bench for alu_sort_driver wired to a behavioural lab ALU (WIDTH=32, N=4).
// Expected sorted words are queued at load time and popped as the DUT emits them.
module tb_alu_sort_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        busy;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_m;
    logic [31:0] alu_y;
    logic        alu_cf;
    logic        alu_of;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    alu_sort_driver #(.WIDTH(32), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_m     (alu_m),
        .alu_y     (alu_y),
        .alu_cf    (alu_cf),
        .alu_of    (alu_of)
    );

    // Lab ALU, SUB path: y = a - b, cf = borrow, of = signed overflow.
    assign alu_y  = alu_a - alu_b;
    assign alu_cf = (alu_a < alu_b);
    assign alu_of = (alu_a[31] != alu_b[31]) && (alu_y[31] != alu_a[31]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_lt(input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_SORT_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    task automatic push_sorted(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [31:0] d);
        logic [31:0] v[4];
        logic [31:0] t;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 1; i < 4; i++) begin
            for (int k = i; k > 0; k--) begin
                if (model_lt(v[k], v[k-1])) begin
                    t = v[k]; v[k] = v[k-1]; v[k-1] = t;
                end
            end
        end
        for (int i = 0; i < 4; i++) sb_q.push_back(v[i]);
    endtask

    // Ends on the first negedge after the last accept (first SORT cycle).
    task automatic load4(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        logic [31:0] v[4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("load_rdy", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1;
            in_data  = v[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_sort();
        int n;
        n = 0;
        while (busy && n < 50) begin
            chk("sort_rdy", {31'd0, in_ready}, 32'd0);
            chk("sort_m", {29'd0, alu_m}, 32'd1);
            in_valid = 1'b1;
            in_data  = 32'hDEAD_BEEF;
            n++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("sort_cycles", n, 32'd6);
        chk("post_sort_vld", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic drain(input bit hold);
        logic [31:0] exp;
        int          n;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("out_vld", {31'd0, out_valid}, 32'd1);
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
                exp = '0;
            end else begin
                exp = sb_q.pop_front();
            end
            chk("out_dat", out_data, exp);
            if (hold && k == 0) begin
                for (int h = 0; h < 5; h++) begin
                    @(negedge clk);
                    chk("hold_vld", {31'd0, out_valid}, 32'd1);
                    chk("hold_dat", out_data, exp);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        chk("done_rdy", {31'd0, in_ready}, 32'd1);
        chk("done_vld", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run_batch(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] d, input bit hold);
        push_sorted(a, b, c, d);
        load4(a, b, c, d);
        wait_sort();
        drain(hold);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdy",  {31'd0, in_ready},  32'd1);
        chk("rst_vld",  {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy},      32'd0);
        chk("rst_a",    alu_a,              32'd0);
        chk("rst_b",    alu_b,              32'd0);
        chk("rst_m",    {29'd0, alu_m},     32'd1);
        rst = 1'b0;

        run_batch(32'd7, 32'd3, 32'd9, 32'd1, 1'b1);
        run_batch(32'd5, 32'd5, 32'd2, 32'd5, 1'b0);
        run_batch(32'hFFFF_FFFF, 32'd1, 32'd0, 32'h8000_0000, 1'b0);

        // Abort mid-sort: nothing may come out of the discarded batch.
        load4(32'd9, 32'd8, 32'd7, 32'd6);
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_rdy",  {31'd0, in_ready},  32'd1);
        chk("abort_vld",  {31'd0, out_valid}, 32'd0);
        chk("abort_busy0", {31'd0, busy},     32'd0);
        chk("abort_a",    alu_a,              32'd0);

        run_batch(32'd4, 32'd3, 32'd2, 32'd1, 1'b0);
        run_batch(32'd1, 32'd2, 32'd3, 32'd4, 1'b0);
        chk("sb_left", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
